// File: rtl/kyber_zeta_seq_pkg.sv
// Shared definitions for the Kyber twiddle-factor sequencer.
//   state_t   : sequencer FSM states
//   ZETA_Q    : default modulus (3329)
//   ZETA      : 128-entry twiddle table, entry i = 17^(-brv7(i)) mod Q
//               anchors: [0]=0x001 [1]=0x640 [2]=0x028 [3]=0x2ED [127]=0xCF0
package kyber_zeta_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int unsigned ZETA_Q = 3329;
  localparam int unsigned ZETA_W = 12;

  typedef logic [127:0][ZETA_W-1:0] zeta_tab_t;

  // Builds the table at elaboration time. 17 is a primitive 256th root of
  // unity mod Q, so 17^(-e) == 17^(256-e); the 8-bit wrap of (256 - br)
  // maps br=0 to exponent 0.
  function automatic zeta_tab_t zeta_gen();
    zeta_tab_t            tab;
    logic [255:0][ZETA_W-1:0] pw;
    int unsigned          br;
    tab   = '0;
    pw    = '0;
    pw[0] = ZETA_W'(1);
    for (int unsigned k = 1; k < 256; k++)
      pw[8'(k)] = ZETA_W'((32'(pw[8'(k - 1)]) * 32'd17) % ZETA_Q);
    for (int unsigned i = 0; i < 128; i++) begin
      br = 0;
      for (int unsigned b = 0; b < 7; b++)
        br = br | (((i >> b) & 32'd1) << (6 - b));
      tab[7'(i)] = pw[8'(256 - br)];
    end
    return tab;
  endfunction

  localparam zeta_tab_t ZETA = zeta_gen();

endpackage

// File: rtl/kyber_zeta_seq_rom.sv
// Synchronous twiddle ROM with clock enable, one cycle read latency.
// No reset on the output register so it maps onto block ROM.
//   clk  : clock
//   ce   : read enable; data holds when low
//   addr : table index
//   data : table entry, valid the cycle after a read with ce=1
module kyber_zeta_rom
  import kyber_zeta_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (ce) data <= DATA_W'(ZETA[addr]);
  end

endmodule

// File: rtl/kyber_zeta_seq.sv
// Streams a burst of twiddle factors from the zeta ROM, ascending (forward)
// or descending (inverse, optionally negated mod Q), with valid/ready output.
//   clk, reset          : clock, asynchronous active-high reset
//   start, mode         : burst request (accepted when busy=0), 0=fwd 1=inv
//   start_addr, length  : first index, number of beats (0..2^ADDR_W)
//   busy, done          : burst in progress, one-cycle completion pulse
//   out_valid/out_ready : output handshake
//   out_data, out_index : twiddle value and its raw table index
module kyber_zeta_seq
  import kyber_zeta_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned Q       = ZETA_Q,
  parameter bit          NEG_INV = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index
);

  state_t              state;
  logic                mode_r;
  logic [ADDR_W-1:0]   addr_cnt;
  logic [ADDR_W:0]     issue_left;
  logic [ADDR_W:0]     beats_left;
  logic                v1;
  logic [ADDR_W-1:0]   idx1;
  logic [DATA_W-1:0]   rom_data;

  logic                advance;
  logic                accept;
  logic                issue;
  logic                fire;
  logic                step_mode;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic [DATA_W-1:0]   beat_data;

  // The first read is issued from IDLE in the accept cycle itself so the
  // first beat reaches the output two cycles after start.
  always_comb begin
    advance   = out_ready | ~out_valid;
    accept    = (state == IDLE) & start;
    issue     = (accept & (length != '0)) |
                ((state == RUN) & advance & (issue_left != '0));
    rd_addr   = (state == IDLE) ? start_addr : addr_cnt;
    step_mode = (state == IDLE) ? mode : mode_r;
    next_addr = step_mode ? rd_addr - ADDR_W'(1) : rd_addr + ADDR_W'(1);
    fire      = out_valid & out_ready;
    beat_data = (NEG_INV && mode_r && (rom_data != '0)) ? DATA_W'(Q) - rom_data
                                                        : rom_data;
  end

  kyber_zeta_rom #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rom (
    .clk (clk),
    .ce  (advance),
    .addr(rd_addr),
    .data(rom_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_r     <= 1'b0;
      addr_cnt   <= '0;
      issue_left <= '0;
      beats_left <= '0;
    end else begin
      done <= 1'b0;
      if (issue) addr_cnt <= next_addr;
      if (fire) beats_left <= beats_left - (ADDR_W+1)'(1);
      case (state)
        IDLE: begin
          if (accept) begin
            mode_r     <= mode;
            beats_left <= length;
            busy       <= 1'b1;
            if (length == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= RUN;
              issue_left <= length - (ADDR_W+1)'(1);
            end
          end
        end
        RUN: begin
          if (issue_left == '0) begin
            state <= DRAIN;
          end else if (advance) begin
            issue_left <= issue_left - (ADDR_W+1)'(1);
            if (issue_left == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fire && (beats_left == (ADDR_W+1)'(1))) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-stage pipeline (ROM register, output register) under one global
  // stall: nothing moves while a valid beat waits for out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      idx1      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else if (advance) begin
      v1        <= issue;
      idx1      <= rd_addr;
      out_valid <= v1;
      if (v1) begin
        out_index <= idx1;
        out_data  <= beat_data;
      end
    end
  end

endmodule

// File: tb/tb_kyber_zeta_seq.sv
// Self-checking bench for kyber_zeta_seq: directed bursts with hand-computed
// twiddles, edge cases and a randomly back-pressured full-table burst.
module tb_kyber_zeta_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [6:0]  start_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [6:0]  out_index;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned fwd_d [4] = '{32'h001, 32'h640, 32'h028, 32'h2ED};

  kyber_zeta_seq #(
    .DATA_W (12),
    .ADDR_W (7),
    .Q      (3329),
    .NEG_INV(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: 17^(256 - brv7(i)) mod 3329 by square-and-multiply.
  function automatic int unsigned zeta_ref(input int unsigned i);
    int unsigned br;
    int unsigned e;
    int unsigned r;
    int unsigned b;
    br = 0;
    for (int k = 0; k < 7; k++)
      if (((i >> k) & 1) != 0) br = br | (32'd1 << (6 - k));
    e = (256 - br) % 256;
    r = 1;
    b = 17;
    while (e != 0) begin
      if ((e & 1) != 0) r = (r * b) % 3329;
      b = (b * b) % 3329;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned inv_ref(input int unsigned i);
    int unsigned z;
    z = zeta_ref(i);
    return (z == 0) ? 0 : 3329 - z;
  endfunction

  // Leaves the bench in the cycle after the accept edge (T+1).
  task automatic start_burst(input logic m, input int unsigned a, input int unsigned l);
    start      = 1'b1;
    mode       = m;
    start_addr = 7'(a);
    length     = 8'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int unsigned idx, input int unsigned data);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_index"}, 32'(out_index), idx);
    check({tag, "_data"},  32'(out_data),  data);
  endtask

  task automatic check_done_then_idle(input string tag);
    tick();
    check({tag, "_done"},      32'(done), 1);
    check({tag, "_fin_valid"}, 32'(out_valid), 0);
    tick();
    check({tag, "_done_clr"},  32'(done), 0);
    check({tag, "_busy_clr"},  32'(busy), 0);
  endtask

  int unsigned beats;
  int unsigned order_err;
  int unsigned stall_err;
  int unsigned quiet_err;
  logic        seen_done;
  logic        prev_stall;
  logic [11:0] prev_d;
  logic [6:0]  prev_i;
  int unsigned exp_i;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    mode       = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b1;
    #1;
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_index", 32'(out_index), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Forward burst from 0, four beats, no bubbles.
    start_burst(1'b0, 0, 4);
    check("fwd_t1_valid", 32'(out_valid), 0);
    check("fwd_t1_busy",  32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_beat("fwd", k, fwd_d[k]);
    end
    check_done_then_idle("fwd");

    // Started in the first idle cycle after FIN: inverse with negation.
    start_burst(1'b1, 1, 2);
    tick();
    check_beat("inv0", 1, 32'h6C1);
    tick();
    check_beat("inv1", 0, 32'hD00);
    check_done_then_idle("inv");

    // Forward wrap 127 -> 0.
    start_burst(1'b0, 127, 2);
    tick();
    check_beat("wrap0", 127, 32'hCF0);
    tick();
    check_beat("wrap1", 0, 32'h001);
    check_done_then_idle("wrap");

    // Zero length: straight to FIN, no beats.
    start_burst(1'b0, 3, 0);
    check("len0_done",  32'(done), 1);
    check("len0_busy",  32'(busy), 1);
    check("len0_valid", 32'(out_valid), 0);
    tick();
    check("len0_done_clr", 32'(done), 0);
    check("len0_busy_clr", 32'(busy), 0);
    check("len0_valid2",   32'(out_valid), 0);

    // Start while busy must not disturb the running burst.
    start_burst(1'b0, 10, 3);
    start      = 1'b1;
    mode       = 1'b1;
    start_addr = 7'd50;
    length     = 8'd5;
    tick();
    check_beat("ign0", 10, zeta_ref(10));
    tick();
    start = 1'b0;
    check_beat("ign1", 11, zeta_ref(11));
    tick();
    check_beat("ign2", 12, zeta_ref(12));
    check_done_then_idle("ign");
    quiet_err = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid || busy) quiet_err++;
    end
    check("ign_quiet", quiet_err, 0);

    // Reset in the middle of the fourth beat.
    start_burst(1'b0, 0, 8);
    for (int k = 0; k < 4; k++) tick();
    check_beat("rstmid_b3", 3, 32'h2ED);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_valid", 32'(out_valid), 0);
    check("rstmid_data",  32'(out_data), 0);
    check("rstmid_index", 32'(out_index), 0);
    check("rstmid_busy",  32'(busy), 0);
    check("rstmid_done",  32'(done), 0);
    tick();
    tick();
    #2;
    reset = 1'b0;
    quiet_err = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid || busy || done) quiet_err++;
    end
    check("rstmid_quiet", quiet_err, 0);

    // Full-table inverse burst from 5 with random back-pressure.
    start_burst(1'b1, 5, 128);
    beats      = 0;
    order_err  = 0;
    stall_err  = 0;
    seen_done  = 1'b0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_i     = '0;
    for (int c = 0; c < 2000 && !seen_done; c++) begin
      if (prev_stall && (!out_valid || out_data !== prev_d || out_index !== prev_i))
        stall_err++;
      if (done) seen_done = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        exp_i = (5 + 128 - (beats % 128)) % 128;
        if (32'(out_index) != exp_i || 32'(out_data) != inv_ref(exp_i)) order_err++;
        beats++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_d     = out_data;
      prev_i     = out_index;
      tick();
    end
    out_ready = 1'b1;
    check("bp_done_seen", 32'(seen_done), 1);
    check("bp_beats",     beats, 128);
    check("bp_order",     order_err, 0);
    check("bp_stable",    stall_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
